// File: rtl/frame_write_ctrl.sv
// Frame write controller: steers framed input beats into a FIFO, tracks frame
// length, and publishes a rewound stop address when a frame's trailer arrives.
module frame_write_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int TRAIL_LEN  = 24,
  parameter int MAX_LEN    = 256,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  in_ready,
  input  logic                  wfull,
  input  logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  winc,
  output logic [ADDR_WIDTH-1:0] stop_addr,
  output logic                  stop_valid,
  output logic                  pkt_done,
  output logic [LEN_WIDTH-1:0]  pkt_len,
  output logic [7:0]            err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    DROP
  } state_t;

  localparam logic [LEN_WIDTH-1:0]  MAX_LEN_L = LEN_WIDTH'(MAX_LEN);
  localparam logic [ADDR_WIDTH-1:0] TRAIL_L   = ADDR_WIDTH'(TRAIL_LEN);

  state_t                state;
  state_t                state_next;
  logic [LEN_WIDTH-1:0]  length;
  logic [LEN_WIDTH-1:0]  length_next;
  logic                  accept;
  logic                  write_beat;
  logic                  complete;
  logic                  raise_err;
  logic                  clear_stop;
  logic [LEN_WIDTH-1:0]  done_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      length <= '0;
    end else begin
      state  <= state_next;
      length <= length_next;
    end
  end

  // The trailer beat is never written and takes priority over a start marker;
  // in DROP everything is swallowed until the trailer resynchronises us.
  always_comb begin
    state_next  = state;
    length_next = length;
    write_beat  = 1'b0;
    complete    = 1'b0;
    raise_err   = 1'b0;
    clear_stop  = 1'b0;
    done_len    = '0;
    in_ready    = (state == DROP) ? 1'b1 : !wfull;
    accept      = in_valid && in_ready;

    if (accept) begin
      case (state)
        IDLE: begin
          if (in_sop && in_eop) begin
            complete    = 1'b1;
            done_len    = '0;
            length_next = '0;
          end else if (in_sop) begin
            write_beat  = 1'b1;
            length_next = LEN_WIDTH'(1);
            clear_stop  = 1'b1;
            state_next  = PAYLOAD;
          end else begin
            raise_err = 1'b1;
          end
        end

        PAYLOAD: begin
          if (in_eop) begin
            complete    = 1'b1;
            done_len    = length;
            length_next = '0;
            state_next  = IDLE;
          end else if (in_sop) begin
            raise_err   = 1'b1;
            write_beat  = 1'b1;
            length_next = LEN_WIDTH'(1);
          end else if (length < MAX_LEN_L) begin
            write_beat  = 1'b1;
            length_next = length + LEN_WIDTH'(1);
          end else begin
            raise_err   = 1'b1;
            length_next = '0;
            state_next  = DROP;
          end
        end

        DROP: begin
          if (in_eop) begin
            state_next = IDLE;
          end
        end

        default: begin
          state_next  = IDLE;
          length_next = '0;
        end
      endcase
    end
  end

  assign winc  = write_beat && !rst;
  assign wdata = winc ? in_data : '0;

  // Frame results are captured on the edge after the trailer beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      stop_addr  <= '0;
      stop_valid <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_len    <= '0;
      err_cnt    <= '0;
    end else begin
      pkt_done <= complete;
      if (complete) begin
        stop_addr  <= waddr - TRAIL_L;
        pkt_len    <= done_len;
        stop_valid <= 1'b1;
      end else if (clear_stop) begin
        stop_valid <= 1'b0;
      end
      if (raise_err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Bench for frame_write_ctrl: vector table, directed corner sequences and
// randomized traffic checked against a frame-level reference model.
module tb_frame_write_ctrl;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam int TL = 24;
  localparam int ML = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_sop;
  logic          in_eop;
  logic          in_ready;
  logic          wfull;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          winc;
  logic [AW-1:0] stop_addr;
  logic          stop_valid;
  logic          pkt_done;
  logic [LW-1:0] pkt_len;
  logic [7:0]    err_cnt;

  always #5 clk = ~clk;

  frame_write_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TRAIL_LEN (TL),
    .MAX_LEN   (ML),
    .LEN_WIDTH (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_ready  (in_ready),
    .wfull     (wfull),
    .waddr     (waddr),
    .wdata     (wdata),
    .winc      (winc),
    .stop_addr (stop_addr),
    .stop_valid(stop_valid),
    .pkt_done  (pkt_done),
    .pkt_len   (pkt_len),
    .err_cnt   (err_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_winc   = 0;
  int n_done   = 0;

  // Reference model: frame-level bookkeeping only.
  bit m_in_frame, m_drop, m_stop_valid, m_done;
  int m_len, m_stop_addr, m_pkt_len, m_err;
  bit e_ready, e_winc;
  int e_wdata;

  logic          s_ready, s_winc;
  logic [DW-1:0] s_wdata;

  typedef struct {
    logic          v, s, e;
    logic [DW-1:0] d;
    logic          wf;
    logic [AW-1:0] wa;
    logic          x_ready, x_winc, x_done;
    logic [AW-1:0] x_stop;
    logic [LW-1:0] x_len;
    logic [7:0]    x_err;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0; m_drop = 0; m_stop_valid = 0; m_done = 0;
    m_len = 0; m_stop_addr = 0; m_pkt_len = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input bit s, input bit e, input int d,
                            input bit wf, input int wa);
    bit acc, err, done;
    e_ready = m_drop ? 1'b1 : !wf;
    acc     = v && e_ready;
    e_winc  = 0; err = 0; done = 0;
    if (acc) begin
      if (m_drop) begin
        if (e) m_drop = 0;
      end else if (m_in_frame) begin
        if (e) begin
          done = 1; m_pkt_len = m_len; m_in_frame = 0;
        end else if (s) begin
          err = 1; e_winc = 1; m_len = 1;
        end else if (m_len < ML) begin
          e_winc = 1; m_len = m_len + 1;
        end else begin
          err = 1; m_drop = 1; m_in_frame = 0;
        end
      end else begin
        if (s && e) begin
          done = 1; m_pkt_len = 0;
        end else if (s) begin
          e_winc = 1; m_len = 1; m_stop_valid = 0; m_in_frame = 1;
        end else begin
          err = 1;
        end
      end
    end
    e_wdata = e_winc ? d : 0;
    if (done) begin
      m_stop_addr  = (wa + (1 << AW) - TL) % (1 << AW);
      m_stop_valid = 1;
    end
    m_done = done;
    if (err && m_err < 255) m_err = m_err + 1;
  endtask

  // Drive one cycle, sample combinational outputs mid-cycle, advance model.
  task automatic apply_stimulus(input bit v, input bit s, input bit e, input int d,
                                input bit wf, input int wa);
    in_valid = v; in_sop = s; in_eop = e; in_data = DW'(d);
    wfull = wf; waddr = AW'(wa);
    @(negedge clk);
    s_ready = in_ready; s_winc = winc; s_wdata = wdata;
    if (s_winc === 1'b1) n_winc++;
    model_step(v, s, e, d, wf, wa);
    @(posedge clk);
    #1;
    if (pkt_done === 1'b1) n_done++;
  endtask

  task automatic check_output(input string tag);
    chk({tag, ".in_ready"},   s_ready,    e_ready);
    chk({tag, ".winc"},       s_winc,     e_winc);
    chk({tag, ".wdata"},      s_wdata,    e_wdata);
    chk({tag, ".pkt_done"},   pkt_done,   m_done);
    chk({tag, ".stop_valid"}, stop_valid, m_stop_valid);
    chk({tag, ".stop_addr"},  stop_addr,  m_stop_addr);
    chk({tag, ".pkt_len"},    pkt_len,    m_pkt_len);
    chk({tag, ".err_cnt"},    err_cnt,    m_err);
  endtask

  task automatic beat(input string tag, input bit s, input bit e, input int d, input int wa);
    apply_stimulus(1, s, e, d, 0, wa);
    check_output(tag);
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 1; in_sop = 1; in_eop = 0; in_data = 8'hA5; wfull = 0;
    @(negedge clk);
    chk("rst.winc", winc, 0);
    chk("rst.wdata", wdata, 0);
    @(posedge clk);
    #1;
    chk("rst.stop_addr", stop_addr, 0);
    chk("rst.stop_valid", stop_valid, 0);
    chk("rst.pkt_done", pkt_done, 0);
    chk("rst.pkt_len", pkt_len, 0);
    chk("rst.err_cnt", err_cnt, 0);
    rst = 0; in_valid = 0; in_sop = 0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0, e0, d0;
    rst = 1; in_valid = 0; in_sop = 0; in_eop = 0; in_data = 0; wfull = 0; waddr = 0;
    @(posedge clk);
    #1;
    do_reset();

    //           v  s  e  d      wf wa   rdy winc done stop len err
    tbl[0]  = '{1, 1, 0, 8'h11, 0, 0,   1, 1, 0, 0,   0, 0};
    tbl[1]  = '{1, 0, 0, 8'h22, 0, 0,   1, 1, 0, 0,   0, 0};
    tbl[2]  = '{1, 0, 0, 8'h33, 0, 0,   1, 1, 0, 0,   0, 0};
    tbl[3]  = '{1, 0, 0, 8'h44, 0, 0,   1, 1, 0, 0,   0, 0};
    tbl[4]  = '{1, 0, 1, 8'h99, 0, 100, 1, 0, 1, 76,  4, 0};
    tbl[5]  = '{0, 0, 0, 8'h00, 0, 0,   1, 0, 0, 76,  4, 0};
    tbl[6]  = '{1, 1, 0, 8'h55, 0, 0,   1, 1, 0, 76,  4, 0};
    tbl[7]  = '{1, 0, 1, 8'h66, 0, 10,  1, 0, 1, 498, 1, 0};
    tbl[8]  = '{0, 0, 0, 8'h00, 0, 0,   1, 0, 0, 498, 1, 0};
    tbl[9]  = '{1, 0, 0, 8'h77, 0, 0,   1, 0, 0, 498, 1, 1};
    tbl[10] = '{1, 1, 1, 8'h88, 0, 30,  1, 0, 1, 6,   0, 1};
    tbl[11] = '{1, 1, 0, 8'hAA, 1, 0,   0, 0, 0, 6,   0, 1};

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d, tbl[i].wf, tbl[i].wa);
      chk($sformatf("tbl%0d.in_ready", i),  s_ready,  tbl[i].x_ready);
      chk($sformatf("tbl%0d.winc", i),      s_winc,   tbl[i].x_winc);
      chk($sformatf("tbl%0d.wdata", i),     s_wdata,  tbl[i].x_winc ? tbl[i].d : 8'h00);
      chk($sformatf("tbl%0d.pkt_done", i),  pkt_done, tbl[i].x_done);
      chk($sformatf("tbl%0d.stop_addr", i), stop_addr, tbl[i].x_stop);
      chk($sformatf("tbl%0d.pkt_len", i),   pkt_len,  tbl[i].x_len);
      chk($sformatf("tbl%0d.err_cnt", i),   err_cnt,  tbl[i].x_err);
    end

    // Back-pressure mid-frame: the stalled beat is presented throughout.
    do_reset();
    w0 = n_winc;
    beat("bp", 1, 0, 1, 0);
    beat("bp", 0, 0, 2, 0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 0, 0, 3, 1, 0);
      check_output("bp.full");
      chk("bp.full_ready", s_ready, 0);
    end
    beat("bp", 0, 0, 3, 0);
    beat("bp", 0, 1, 0, 200);
    chk("bp.pkt_len", pkt_len, 3);
    chk("bp.stop_addr", stop_addr, 176);
    chk("bp.winc_count", n_winc - w0, 3);

    // Overflow: 10 payload beats with MAX_LEN=8, then a clean frame.
    w0 = n_winc; e0 = err_cnt; d0 = n_done;
    beat("ovf", 1, 0, 0, 0);
    for (int i = 1; i < 10; i++) beat("ovf", 0, 0, i, 0);
    beat("ovf", 0, 1, 0, 50);
    chk("ovf.winc_count", n_winc - w0, 8);
    chk("ovf.err_delta", err_cnt - e0, 1);
    chk("ovf.no_done", n_done - d0, 0);
    chk("ovf.stop_kept", stop_addr, 176);
    beat("ovf2", 1, 0, 7, 0);
    beat("ovf2", 0, 0, 8, 0);
    beat("ovf2", 0, 0, 9, 0);
    beat("ovf2", 0, 1, 0, 60);
    chk("ovf2.pkt_done", pkt_done, 1);
    chk("ovf2.pkt_len", pkt_len, 3);

    // Restart marker inside a frame.
    e0 = err_cnt;
    beat("rs", 1, 0, 1, 0);
    beat("rs", 0, 0, 2, 0);
    beat("rs", 1, 0, 3, 0);
    for (int i = 0; i < 3; i++) beat("rs", 0, 0, 4 + i, 0);
    beat("rs", 0, 1, 0, 70);
    chk("rs.err_delta", err_cnt - e0, 1);
    chk("rs.pkt_len", pkt_len, 4);

    // Reset mid-frame, then a normal frame.
    beat("mr", 1, 0, 1, 0);
    beat("mr", 0, 0, 2, 0);
    do_reset();
    beat("mr2", 1, 0, 5, 0);
    beat("mr2", 0, 0, 6, 0);
    beat("mr2", 0, 1, 0, 300);
    chk("mr2.pkt_len", pkt_len, 2);
    chk("mr2.stop_addr", stop_addr, 276);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus($urandom_range(99, 0) < 75, $urandom_range(99, 0) < 15,
                     $urandom_range(99, 0) < 12, int'($urandom_range(255, 0)),
                     $urandom_range(99, 0) < 20, int'($urandom_range(511, 0)));
      check_output("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
